bus_dev_fifo: RTL and testbench
===============================

Name: bus_dev_fifo

Overview:
- Per-device endpoint FIFO pair on the device side of the bus generator/arbiter (bs_gnrtr_n_rbtr), one instance per driver slot.
- TX path: host writes packets; the block presents them to the bus via pndng/D_pop and retires them on pop.
- RX path: the block captures bus push/D_push deliveries addressed to this device, or broadcast, and presents them first-word-fall-through (FWFT) to the host.
- Replaces the behavioural driver/monitor queues with synthesizable RTL.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] are the destination ID, the rest is payload.
- depth, 8, entries per FIFO; power of two, at least 2.
- id, 0, this device's 8-bit bus ID.
- broadcast, 8'hFF, destination ID accepted by every device.

Ports:
- clk  in  1  bus clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- tx_wr  in  1  host write strobe.
- tx_data  in  pckg_sz  host packet.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(depth+1)  TX occupancy.
- pndng  out  1  to bus: TX FIFO not empty.
- D_pop  out  pckg_sz  to bus: TX head packet.
- pop  in  1  from bus: retire TX head.
- push  in  1  from bus: packet delivery strobe.
- D_push  in  pckg_sz  from bus: delivered packet.
- rx_rd  in  1  host read strobe.
- rx_data  out  pckg_sz  RX head packet (FWFT).
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  $clog2(depth+1)  RX occupancy.
- err_flags  out  4  sticky flags {rx_misaddr, rx_ovf, tx_udf, tx_ovf}.

Behaviour:
- Reset (reset==0 at a clk edge):
  - pointers and counts go to 0, err_flags go to 0.
  - pndng=0, tx_full=0, rx_empty=1, D_pop=0, rx_data=0.
  - Memory contents are not reset.
  - A reset asserted mid-operation discards all stored packets in that cycle; there is no partial completion.
- TX FIFO (FWFT):
  - pndng = (tx_count != 0).
  - D_pop = memory head when pndng=1, else 0.
  - A write accepted at edge N makes pndng=1 and D_pop valid after edge N. Latency is 1 clk into an empty FIFO.
  - pop with pndng=1 advances the read pointer; the next entry appears on D_pop after the same edge.
  - pop with pndng=0 is ignored and sets tx_udf.
  - tx_wr with tx_full=1 and no pop is dropped and sets tx_ovf.
  - tx_wr together with pop while full: both are accepted and the count is unchanged.
  - tx_wr together with pop while empty: the pop is ignored (tx_udf set), the write is accepted, and the count becomes 1.
- RX FIFO (FWFT):
  - A push is accepted only if D_push[dest] == id or == broadcast.
  - Otherwise the push is dropped and rx_misaddr is set.
  - An accepted push while full (no same-cycle rx_rd) is dropped and sets rx_ovf.
  - push together with rx_rd while full: both are accepted.
  - rx_rd with rx_empty=1 is ignored and sets no flag.
  - rx_data = head when !rx_empty, else 0.
- Pointers are $clog2(depth) bits and wrap modulo depth. Counts saturate logically at depth because overflowing writes are rejected.
- err_flags bits are sticky until reset.

Decomposition:
- Package bus_dev_pkg holds:
  - BCAST_ID = 8'hFF.
  - DEST_W = 8.
  - function get_dest(pkt) returning the top DEST_W bits.
  - err_flags bit-index localparams.
- Sub-module bus_sync_fifo (parameters width and depth; ports wr, rd, din, dout, full, empty, count, ovf, udf) is instantiated twice.
- The top level adds the address filter and the sticky flags.

Test Plan:
- Reset and fill: release reset, then write 16'h0101..16'h0108 (8 writes) -> pndng=1 after the first edge, tx_full=1 after the 8th, tx_count=8. A 9th write 16'h0109 leaves tx_count=8 and sets err_flags[0].
- Drain in order: pulse pop 8 times -> D_pop shows 16'h0101..16'h0108 in order, pndng=0 after the last pop. An extra pop sets err_flags[1].
- Full-boundary simultaneous: with the TX FIFO full, assert tx_wr=16'h0A0A and pop together -> tx_count stays 8, no tx_ovf, and 16'h0A0A emerges last.
- RX address filter (id=2): push 16'h02AA, 16'hFF55 and 16'h03CC -> rx_count=2, rx_data=16'h02AA then 16'hFF55, err_flags[3]=1.
- RX overflow: push 9 packets 16'h0200..16'h0208 with no rx_rd -> rx_count=8, err_flags[2]=1, and 16'h0208 is never read.
- Reset mid-operation: with tx_count=5 and rx_count=3, drive reset=0 for 1 clk -> counts=0, pndng=0, rx_empty=1, err_flags=0, D_pop=0.

Source files
------------

// File: rtl/bus_dev_pkg.sv
// Shared constants and helpers for the per-device bus endpoint FIFOs.
package bus_dev_pkg;

    localparam int          DEST_W    = 8;
    localparam logic [7:0]  BCAST_ID  = 8'hFF;
    localparam int          PKT_MAX_W = 256;

    localparam int ERR_W          = 4;
    localparam int ERR_TX_OVF     = 0;
    localparam int ERR_TX_UDF     = 1;
    localparam int ERR_RX_OVF     = 2;
    localparam int ERR_RX_MISADDR = 3;

    // Caller zero-extends the packet to PKT_MAX_W and passes its real width.
    function automatic logic [DEST_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                   input int pkt_w);
        return DEST_W'(pkt >> (pkt_w - DEST_W));
    endfunction

endpackage

// File: rtl/bus_dev_fifo_if.sv
// Host-side and bus-side signals of one device endpoint.
interface bus_dev_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    import bus_dev_pkg::*;

    localparam int CW = $clog2(depth + 1);

    logic               tx_wr;
    logic [pckg_sz-1:0] tx_data;
    logic               tx_full;
    logic [CW-1:0]      tx_count;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rx_rd;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_empty;
    logic [CW-1:0]      rx_count;
    logic [ERR_W-1:0]   err_flags;

    modport slave (
        input  tx_wr, tx_data, pop, push, D_push, rx_rd,
        output tx_full, tx_count, pndng, D_pop, rx_data, rx_empty, rx_count, err_flags
    );

    modport master (
        output tx_wr, tx_data, pop, push, D_push, rx_rd,
        input  tx_full, tx_count, pndng, D_pop, rx_data, rx_empty, rx_count, err_flags
    );

endinterface

// File: rtl/bus_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero when empty.
module bus_sync_fifo #(
    parameter int  width = 16,
    parameter int  depth = 8,
    localparam int AW    = $clog2(depth),
    localparam int CW    = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf
);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    cnt;
    logic             wr_ok, rd_ok;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(depth));
    assign rd_ok = rd && !empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign wr_ok = wr && (!full || rd_ok);
    assign ovf   = wr && !wr_ok;
    assign udf   = rd && empty;
    assign count = cnt;
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) rptr <= rptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/bus_dev_fifo.sv
// Device endpoint: TX FIFO toward the bus, address-filtered RX FIFO toward the host.
module bus_dev_fifo import bus_dev_pkg::*; #(
    parameter int                pckg_sz   = 16,
    parameter int                depth     = 8,
    parameter logic [DEST_W-1:0] id        = 8'h00,
    parameter logic [DEST_W-1:0] broadcast = BCAST_ID
) (
    input logic          clk,
    input logic          reset,
    bus_dev_fifo_if.slave bus
);

    logic              tx_empty, tx_ovf, tx_udf;
    logic              rx_full, rx_ovf, rx_udf;
    logic              addr_ok, rx_wr, rx_misaddr;
    logic [DEST_W-1:0] dest;
    logic [ERR_W-1:0]  err, err_evt;

    bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.tx_wr),
        .rd    (bus.pop),
        .din   (bus.tx_data),
        .dout  (bus.D_pop),
        .full  (bus.tx_full),
        .empty (tx_empty),
        .count (bus.tx_count),
        .ovf   (tx_ovf),
        .udf   (tx_udf)
    );

    assign bus.pndng = !tx_empty;

    assign dest       = get_dest(PKT_MAX_W'(bus.D_push), pckg_sz);
    assign addr_ok    = (dest == id) || (dest == broadcast);
    assign rx_wr      = bus.push && addr_ok;
    assign rx_misaddr = bus.push && !addr_ok;

    bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .rd    (bus.rx_rd),
        .din   (bus.D_push),
        .dout  (bus.rx_data),
        .full  (rx_full),
        .empty (bus.rx_empty),
        .count (bus.rx_count),
        .ovf   (rx_ovf),
        .udf   (rx_udf)
    );

    // Host reads of an empty RX FIFO are harmless, so RX underflow is not reported.
    logic unused_rx;
    assign unused_rx = &{1'b0, rx_full, rx_udf};

    always_comb begin
        err_evt                 = '0;
        err_evt[ERR_TX_OVF]     = tx_ovf;
        err_evt[ERR_TX_UDF]     = tx_udf;
        err_evt[ERR_RX_OVF]     = rx_ovf;
        err_evt[ERR_RX_MISADDR] = rx_misaddr;
    end

    always_ff @(posedge clk) begin
        if (!reset) err <= '0;
        else        err <= err | err_evt;
    end

    assign bus.err_flags = err;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Scoreboard bench: queue-based endpoint model, negedge monitor, directed + random stimulus.
module tb_bus_dev_fifo;

    localparam int         W     = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] ID    = 8'h02;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_dev_fifo_if #(.pckg_sz(W), .depth(DEPTH)) bus ();

    bus_dev_fifo #(.pckg_sz(W), .depth(DEPTH), .id(ID), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];
    logic [3:0]   flg = '0;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Endpoint behaviour expressed as queue operations on the pre-edge state.
    task automatic model(input logic r, input logic wr, input logic [W-1:0] wd, input logic p,
                         input logic ps, input logic [W-1:0] pd, input logic rd);
        bit pop_ok, wr_ok, hit, rd_ok, acc;
        if (!r) begin
            tx_q.delete();
            rx_q.delete();
            flg = '0;
            return;
        end
        pop_ok = p && (tx_q.size() > 0);
        if (p && tx_q.size() == 0) flg[1] = 1'b1;
        wr_ok = wr && (tx_q.size() < DEPTH || pop_ok);
        if (wr && !wr_ok) flg[0] = 1'b1;
        if (pop_ok) void'(tx_q.pop_front());
        if (wr_ok) tx_q.push_back(wd);
        hit = (pd[W-1 -: 8] == ID) || (pd[W-1 -: 8] == 8'hFF);
        if (ps && !hit) flg[3] = 1'b1;
        rd_ok = rd && (rx_q.size() > 0);
        acc = ps && hit && (rx_q.size() < DEPTH || rd_ok);
        if (ps && hit && !acc) flg[2] = 1'b1;
        if (rd_ok) void'(rx_q.pop_front());
        if (acc) rx_q.push_back(pd);
    endtask

    task automatic cyc(input logic r, input logic wr, input logic [W-1:0] wd, input logic p,
                       input logic ps, input logic [W-1:0] pd, input logic rd);
        reset       = r;
        bus.tx_wr   = wr;
        bus.tx_data = wd;
        bus.pop     = p;
        bus.push    = ps;
        bus.D_push  = pd;
        bus.rx_rd   = rd;
        @(posedge clk);
        model(r, wr, wd, p, ps, pd, rd);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: compare every visible output with the model between edges.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_count", bus.tx_count, tx_q.size());
            chk("rx_count", bus.rx_count, rx_q.size());
            chk("pndng", bus.pndng, tx_q.size() != 0);
            chk("tx_full", bus.tx_full, tx_q.size() == DEPTH);
            chk("rx_empty", bus.rx_empty, rx_q.size() == 0);
            chk("err_flags", bus.err_flags, flg);
            chk("D_pop", bus.D_pop, (tx_q.size() != 0) ? tx_q[0] : '0);
            chk("rx_data", bus.rx_data, (rx_q.size() != 0) ? rx_q[0] : '0);
        end
    end

    logic [W-1:0] drain_exp [DEPTH];

    initial begin
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        idle();
        chk("rst_pndng", bus.pndng, 0);
        chk("rst_rx_empty", bus.rx_empty, 1);
        chk("rst_err", bus.err_flags, 0);
        chk("rst_D_pop", bus.D_pop, 0);

        // Fill TX
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
            if (i == 1) chk("pndng_first", bus.pndng, 1);
        end
        chk("fill_full", bus.tx_full, 1);
        chk("fill_count", bus.tx_count, 8);

        // Write with pop while full: both accepted, no overflow
        cyc(1'b1, 1'b1, 16'h0A0A, 1'b1, 1'b0, '0, 1'b0);
        chk("simul_count", bus.tx_count, 8);
        chk("simul_no_ovf", bus.err_flags[0], 0);

        cyc(1'b1, 1'b1, 16'h0109, 1'b0, 1'b0, '0, 1'b0);
        chk("ovf_count", bus.tx_count, 8);
        chk("ovf_flag", bus.err_flags[0], 1);

        // Drain in order
        for (int i = 0; i < DEPTH - 1; i++) drain_exp[i] = 16'h0102 + 16'(i);
        drain_exp[DEPTH-1] = 16'h0A0A;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", bus.D_pop, drain_exp[i]);
            cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        chk("drain_pndng", bus.pndng, 0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("udf_flag", bus.err_flags[1], 1);

        // RX address filter
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h02AA, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'hFF55, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h03CC, 1'b0);
        chk("filt_count", bus.rx_count, 2);
        chk("filt_misaddr", bus.err_flags[3], 1);
        chk("filt_head0", bus.rx_data, 16'h02AA);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("filt_head1", bus.rx_data, 16'hFF55);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("filt_empty", bus.rx_empty, 1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("rd_empty_noflag", bus.err_flags[2], 0);

        // RX overflow
        for (int i = 0; i <= DEPTH; i++)
            cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
        chk("rxovf_count", bus.rx_count, 8);
        chk("rxovf_flag", bus.err_flags[2], 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("rxovf_order", bus.rx_data, 16'h0200 + 16'(i));
            cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        chk("rxovf_drained", bus.rx_empty, 1);

        // Reset mid-operation
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, 16'h0300 + 16'(i), 1'b0, i < 3, 16'h0210 + 16'(i), 1'b0);
        chk("pre_rst_tx", bus.tx_count, 5);
        chk("pre_rst_rx", bus.rx_count, 3);
        cyc(1'b0, 1'b1, 16'h0BAD, 1'b1, 1'b1, 16'h02EE, 1'b1);
        chk("mid_rst_tx", bus.tx_count, 0);
        chk("mid_rst_rx", bus.rx_count, 0);
        chk("mid_rst_pndng", bus.pndng, 0);
        chk("mid_rst_rx_empty", bus.rx_empty, 1);
        chk("mid_rst_err", bus.err_flags, 0);
        chk("mid_rst_D_pop", bus.D_pop, 0);

        // Random traffic, alternating fill-heavy and drain-heavy phases
        for (int seg = 0; seg < 10; seg++) begin
            int wp, pp;
            wp = seg[0] ? 25 : 75;
            pp = seg[0] ? 75 : 25;
            for (int n = 0; n < 300; n++) begin
                logic [W-1:0] pd;
                logic [7:0]   dst;
                case ($urandom_range(0, 3))
                    0:       dst = ID;
                    1:       dst = 8'hFF;
                    2:       dst = 8'h03;
                    default: dst = 8'($urandom);
                endcase
                pd = {dst, 8'($urandom)};
                cyc($urandom_range(0, 499) != 0,
                    $urandom_range(0, 99) < wp, 16'($urandom),
                    $urandom_range(0, 99) < pp,
                    $urandom_range(0, 99) < wp, pd,
                    $urandom_range(0, 99) < pp);
            end
        end
        idle();
        idle();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
